ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 137 +++++++++++++
 tb/tb_ex_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of a five-stage RV32 pipeline: ALU, branch/jump resolution and EX/MEM register.
// Define EX_FORWARD_EN to add the forwardae/forwardbe operand bypass selects.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwritee,
  input  logic        memwritee,
  input  logic        jumpe,
  input  logic        jalre,
  input  logic        branche,
  input  logic        alusrce,
  input  logic [1:0]  resultsrce,
  input  logic [3:0]  aluctrle,
  input  logic [2:0]  funct3e,
  input  logic [4:0]  rde,
  input  logic [4:0]  rs1e,
  input  logic [4:0]  rs2e,
  input  logic [31:0] rd1e,
  input  logic [31:0] rd2e,
  input  logic [31:0] immexte,
  input  logic [31:0] pcde,
  input  logic [31:0] pc4de,
  input  logic [31:0] resultw,
  input  logic        stallm,
`ifdef EX_FORWARD_EN
  input  logic [1:0]  forwardae,
  input  logic [1:0]  forwardbe,
`endif
  output logic        pcsrce,
  output logic [31:0] pctargete,
  output logic        regwritem,
  output logic        memwritem,
  output logic [1:0]  resultsrcm,
  output logic [31:0] aluresultm,
  output logic [31:0] writedatam,
  output logic [31:0] pc4m,
  output logic [4:0]  rdm,
  output logic [31:0] redirect_cnt
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] srcb;
  logic [31:0] alu_result;
  logic [4:0]  shamt;
  logic        cond;

`ifdef EX_FORWARD_EN
  // Code 11 is unused by the hazard unit and falls back to the register file value.
  always_comb begin
    fwd_a = rd1e;
    fwd_b = rd2e;
    case (forwardae)
      2'b01:   fwd_a = resultw;
      2'b10:   fwd_a = aluresultm;
      default: fwd_a = rd1e;
    endcase
    case (forwardbe)
      2'b01:   fwd_b = resultw;
      2'b10:   fwd_b = aluresultm;
      default: fwd_b = rd2e;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{rs1e, rs2e};
`else
  assign fwd_a = rd1e;
  assign fwd_b = rd2e;

  logic unused_bits;
  assign unused_bits = ^{rs1e, rs2e, resultw};
`endif

  assign srcb  = alusrce ? immexte : fwd_b;
  assign shamt = srcb[4:0];

  always_comb begin
    alu_result = 32'd0;
    case (aluctrle)
      4'b0000: alu_result = fwd_a + srcb;
      4'b0001: alu_result = fwd_a - srcb;
      4'b0010: alu_result = fwd_a & srcb;
      4'b0011: alu_result = fwd_a | srcb;
      4'b0100: alu_result = fwd_a ^ srcb;
      4'b0101: alu_result = fwd_a << shamt;
      4'b0110: alu_result = {31'd0, $signed(fwd_a) < $signed(srcb)};
      4'b0111: alu_result = {31'd0, fwd_a < srcb};
      4'b1000: alu_result = $unsigned($signed(fwd_a) >>> shamt);
      4'b1001: alu_result = fwd_a >> shamt;
      default: alu_result = 32'd0;
    endcase
  end

  // Branch compare uses the forwarded register operands, never the immediate.
  always_comb begin
    cond = 1'b0;
    case (funct3e)
      3'b000:  cond = (fwd_a == fwd_b);
      3'b001:  cond = (fwd_a != fwd_b);
      3'b100:  cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  cond = !($signed(fwd_a) < $signed(fwd_b));
      3'b110:  cond = (fwd_a < fwd_b);
      3'b111:  cond = !(fwd_a < fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign pcsrce    = !stallm & (jumpe | (branche & cond));
  assign pctargete = jalre ? ((fwd_a + immexte) & ~32'd1) : (pcde + immexte);

  // pcsrce is already gated by stallm, so the counter freezes with the register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regwritem    <= 1'b0;
      memwritem    <= 1'b0;
      resultsrcm   <= 2'd0;
      aluresultm   <= 32'd0;
      writedatam   <= 32'd0;
      pc4m         <= 32'd0;
      rdm          <= 5'd0;
      redirect_cnt <= 32'd0;
    end else if (!stallm) begin
      regwritem  <= regwritee;
      memwritem  <= memwritee;
      resultsrcm <= resultsrce;
      aluresultm <= alu_result;
      writedatam <= fwd_b;
      pc4m       <= pc4de;
      rdm        <= rde;
      if (pcsrce) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases then randomized traffic against a behavioural model.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        regwritee, memwritee, jumpe, jalre, branche, alusrce;
  logic [1:0]  resultsrce;
  logic [3:0]  aluctrle;
  logic [2:0]  funct3e;
  logic [4:0]  rde, rs1e, rs2e;
  logic [31:0] rd1e, rd2e, immexte, pcde, pc4de, resultw;
  logic        stallm;
  logic [1:0]  forwardae, forwardbe;
  logic        pcsrce;
  logic [31:0] pctargete;
  logic        regwritem, memwritem;
  logic [1:0]  resultsrcm;
  logic [31:0] aluresultm, writedatam, pc4m, redirect_cnt;
  logic [4:0]  rdm;

  // Model of the EX/MEM register contents.
  logic        m_regwrite, m_memwrite;
  logic [1:0]  m_resultsrc;
  logic [31:0] m_aluresult, m_writedata, m_pc4, m_cnt;
  logic [4:0]  m_rd;

  int checks;
  int errors;

  ex_stage dut (
    .clk(clk), .rst(rst),
    .regwritee(regwritee), .memwritee(memwritee), .jumpe(jumpe), .jalre(jalre),
    .branche(branche), .alusrce(alusrce), .resultsrce(resultsrce),
    .aluctrle(aluctrle), .funct3e(funct3e),
    .rde(rde), .rs1e(rs1e), .rs2e(rs2e),
    .rd1e(rd1e), .rd2e(rd2e), .immexte(immexte), .pcde(pcde), .pc4de(pc4de),
    .resultw(resultw), .stallm(stallm),
`ifdef EX_FORWARD_EN
    .forwardae(forwardae), .forwardbe(forwardbe),
`endif
    .pcsrce(pcsrce), .pctargete(pctargete),
    .regwritem(regwritem), .memwritem(memwritem), .resultsrcm(resultsrcm),
    .aluresultm(aluresultm), .writedatam(writedatam), .pc4m(pc4m),
    .rdm(rdm), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned wide;
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: begin
        wide = longint'(a) * (longint'(1) << sh);
        return wide[31:0];
      end
      4'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: begin
        wide = longint'(a) / (longint'(1) << sh);
        return a[31] ? ~((~a) / (32'd1 << sh)) : wide[31:0];
      end
      4'd9: begin
        wide = longint'(a) / (longint'(1) << sh);
        return wide[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic branch_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] operand_ref(input logic [1:0] sel, input logic [31:0] regval);
`ifdef EX_FORWARD_EN
    if (sel == 2'd1) return resultw;
    if (sel == 2'd2) return m_aluresult;
`endif
    return (sel == 2'd3) ? regval : regval;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("regwritem", {31'd0, regwritem}, {31'd0, m_regwrite});
    check("memwritem", {31'd0, memwritem}, {31'd0, m_memwrite});
    check("resultsrcm", {30'd0, resultsrcm}, {30'd0, m_resultsrc});
    check("aluresultm", aluresultm, m_aluresult);
    check("writedatam", writedatam, m_writedata);
    check("pc4m", pc4m, m_pc4);
    check("rdm", {27'd0, rdm}, {27'd0, m_rd});
    check("redirect_cnt", redirect_cnt, m_cnt);
  endtask

  task automatic modelReset();
    m_regwrite = 0; m_memwrite = 0; m_resultsrc = 0; m_aluresult = 0;
    m_writedata = 0; m_pc4 = 0; m_rd = 0; m_cnt = 0;
  endtask

  // Check the combinational redirect, advance the model, clock once and check the M outputs.
  task automatic applyStimulus();
    logic [31:0] fa, fb, sb, tgt;
    logic        take;
    #1;
    fa   = operand_ref(forwardae, rd1e);
    fb   = operand_ref(forwardbe, rd2e);
    sb   = alusrce ? immexte : fb;
    take = !stallm && (jumpe || (branche && branch_ref(funct3e, fa, fb)));
    tgt  = jalre ? ((fa + immexte) & 32'hFFFF_FFFE) : (pcde + immexte);
    check("pcsrce", {31'd0, pcsrce}, {31'd0, take});
    check("pctargete", pctargete, tgt);
    if (!stallm) begin
      m_regwrite  = regwritee;
      m_memwrite  = memwritee;
      m_resultsrc = resultsrce;
      m_aluresult = alu_ref(aluctrle, fa, sb);
      m_writedata = fb;
      m_pc4       = pc4de;
      m_rd        = rde;
      if (take) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearInputs();
    regwritee = 0; memwritee = 0; jumpe = 0; jalre = 0; branche = 0; alusrce = 0;
    resultsrce = 0; aluctrle = 0; funct3e = 0; rde = 0; rs1e = 0; rs2e = 0;
    rd1e = 0; rd2e = 0; immexte = 0; pcde = 0; pc4de = 0; resultw = 0;
    stallm = 0; forwardae = 0; forwardbe = 0;
  endtask

  task automatic randomInputs();
    regwritee = 1'($urandom); memwritee = 1'($urandom); jumpe = ($urandom_range(0, 5) == 0);
    jalre = 1'($urandom); branche = 1'($urandom); alusrce = 1'($urandom);
    resultsrce = 2'($urandom); aluctrle = 4'($urandom); funct3e = 3'($urandom);
    rde = 5'($urandom); rs1e = 5'($urandom); rs2e = 5'($urandom);
    rd1e = ($urandom_range(0, 3) == 0) ? rd2e : $urandom;
    rd2e = $urandom; immexte = $urandom; pcde = $urandom; pc4de = $urandom;
    resultw = $urandom; stallm = ($urandom_range(0, 4) == 0);
`ifdef EX_FORWARD_EN
    forwardae = 2'($urandom); forwardbe = 2'($urandom);
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    modelReset();
    rst = 1'b0;
    #2;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;

    // add with register operands
    clearInputs();
    aluctrle = 4'd0; rd1e = 32'd5; rd2e = 32'd7; rde = 5'd9; regwritee = 1; pc4de = 32'h44;
    applyStimulus();
    check("add_result", aluresultm, 32'd12);

    // sub wraps, then unsigned and signed compares
    clearInputs();
    aluctrle = 4'd1; rd1e = 32'd0; rd2e = 32'd1;
    applyStimulus();
    check("sub_wrap", aluresultm, 32'hFFFF_FFFF);
    aluctrle = 4'd7;
    applyStimulus();
    check("sltu_0_1", aluresultm, 32'd1);
    rd1e = 32'hFFFF_FFFF; rd2e = 32'd1;
    applyStimulus();
    check("sltu_neg", aluresultm, 32'd0);
    aluctrle = 4'd6;
    applyStimulus();
    check("slt_neg", aluresultm, 32'd1);
    aluctrle = 4'd8; rd1e = 32'h8000_0000; rd2e = 32'd36;
    applyStimulus();
    check("sra_shamt", aluresultm, 32'hF800_0000);
    aluctrle = 4'd12;
    applyStimulus();

    // taken beq
    clearInputs();
    branche = 1; funct3e = 3'b000; rd1e = 32'd3; rd2e = 32'd3; pcde = 32'h100; immexte = 32'h10;
    applyStimulus();
    check("beq_cnt", redirect_cnt, 32'd1);
    funct3e = 3'b010;
    applyStimulus();

    // jalr clears bit 0 of the target
    clearInputs();
    jalre = 1; jumpe = 1; rd1e = 32'h201; immexte = 32'd4; pc4de = 32'h1234;
    #1;
    check("jalr_target", pctargete, 32'h204);
    applyStimulus();
    check("jalr_pc4", pc4m, 32'h1234);

    // stall for three cycles with changing inputs, then reset mid-stall
    for (int i = 0; i < 3; i++) begin
      randomInputs();
      stallm = 1;
      jumpe = 1;
      applyStimulus();
    end
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    aluctrle = 4'd2; rd1e = 32'hF0F0; rd2e = 32'hFF00; rde = 5'd3;
    applyStimulus();

`ifdef EX_FORWARD_EN
    clearInputs();
    aluctrle = 4'd0; alusrce = 1; rd1e = 32'd4; immexte = 32'd5;
    applyStimulus();
    forwardae = 2'b10; rd1e = 32'd0; immexte = 32'd1;
    applyStimulus();
    check("fwd_alu", aluresultm, 32'd10);
    clearInputs();
    memwritee = 1; forwardbe = 2'b01; resultw = 32'hAB; rd2e = 32'h55;
    applyStimulus();
    check("fwd_store", writedatam, 32'hAB);
`endif

    for (int i = 0; i < 300; i++) begin
      randomInputs();
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
